// File: rtl/parity_frame_receiver.sv
// parity_frame_receiver: deserialises start/data/parity/stop frames and flags parity and stop-bit errors
// Ports: clk, rst (sync, active-high), serial_in (idles high), data_out (last byte, held),
//   data_valid (1-cycle pulse), parity_error / frame_error (held with data_out), busy (state != IDLE),
//   err_count (only with PFR_ERR_COUNT_EN: saturating count of errored frames).
module parity_frame_receiver #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serial_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_error,
   output logic              frame_error,
   output logic              busy
`ifdef PFR_ERR_COUNT_EN
   ,output logic [7:0]       err_count
`endif
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;
   state_t            state, state_n;
   logic [CW-1:0]     cyc;
   logic [BW-1:0]     bits;
   logic [DATA_W-1:0] shreg;
   logic              par_err_q;
   logic              tick;
   // the start bit is sampled half a bit in; every later sample is a full bit after the previous one
   always_comb begin
      tick = (state == START) ? (cyc == CW'(CLKS_PER_BIT/2 - 1)) : (cyc == CW'(CLKS_PER_BIT - 1));
      state_n = state;
      case (state)
         IDLE:       state_n = serial_in ? IDLE : START;
         START:      state_n = !tick ? START : serial_in ? IDLE : DATA;
         DATA:       state_n = (tick && bits == BW'(DATA_W - 1)) ? PARITY : DATA;
         PARITY:     state_n = tick ? STOP : PARITY;
         STOP:       state_n = !tick ? STOP : serial_in ? IDLE : BREAK_WAIT;
         BREAK_WAIT: state_n = serial_in ? IDLE : BREAK_WAIT;
         default:    state_n = IDLE;
      endcase
   end
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cyc          <= '0;
         bits         <= '0;
         shreg        <= '0;
         par_err_q    <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
`ifdef PFR_ERR_COUNT_EN
         err_count    <= '0;
`endif
      end else begin
         state      <= state_n;
         data_valid <= 1'b0;
         cyc        <= (state == IDLE || state == BREAK_WAIT || tick) ? '0 : cyc + CW'(1);
         if (state == IDLE) bits <= '0;
         // LSB arrives first, so after DATA_W right-shifts bit i sits in shreg[i]
         if (state == DATA && tick) begin
            shreg <= {serial_in, shreg[DATA_W-1:1]};
            bits  <= bits + BW'(1);
         end
         if (state == PARITY && tick) par_err_q <= (^shreg ^ serial_in) != 1'(PARITY_ODD);
         if (state == STOP && tick) begin
            data_out     <= shreg;
            parity_error <= par_err_q;
            frame_error  <= ~serial_in;
            data_valid   <= 1'b1;
`ifdef PFR_ERR_COUNT_EN
            if ((par_err_q || !serial_in) && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_parity_frame_receiver.sv
// tb_parity_frame_receiver: table, hand-written and random frames against a frame-level reference model
module tb_parity_frame_receiver;
   localparam int CPB = 4;
   localparam int PARITY_ODD = 0;
   localparam int LAT = 43;
   logic clk = 0, rst = 1, serial_in = 1;
   logic [7:0] data_out;
   logic data_valid, parity_error, frame_error, busy;
`ifdef PFR_ERR_COUNT_EN
   logic [7:0] err_count;
`endif
   parity_frame_receiver dut (
      .clk(clk), .rst(rst), .serial_in(serial_in), .data_out(data_out), .data_valid(data_valid),
      .parity_error(parity_error), .frame_error(frame_error), .busy(busy)
`ifdef PFR_ERR_COUNT_EN
      , .err_count(err_count)
`endif
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {logic [7:0] d; logic pe; logic fe; int t;} obs_t;
   obs_t mq[$];
   always @(negedge clk) if (data_valid) mq.push_back('{data_out, parity_error, frame_error, cyc});
   typedef struct {logic [7:0] d; logic flip; logic stop; logic [7:0] xd; logic xpe; logic xfe;} vec_t;
   vec_t tbl[7];
   int checks = 0, errors = 0;
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, act, exp);
      end
   endtask
   task automatic tick_n(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic bit_out(logic b);
      serial_in = b;
      tick_n(CPB);
   endtask
   task automatic send(logic [7:0] d, logic pbit, logic stop, output int t0);
      t0 = cyc;
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(d[i]);
      bit_out(pbit);
      bit_out(stop);
   endtask
   task automatic check_obs(string n, logic [7:0] xd, logic xpe, logic xfe, int t0);
      obs_t o;
      chk({n, "_dv_count"}, mq.size(), 1);
      if (mq.size() > 0) begin
         o = mq.pop_front();
         chk({n, "_data"}, o.d, xd);
         chk({n, "_perr"}, o.pe, xpe);
         chk({n, "_ferr"}, o.fe, xfe);
         chk({n, "_latency"}, o.t - t0, LAT);
      end
      mq.delete();
   endtask
   initial begin
      int t0;
      logic [7:0] d;
      logic flip, stop, pbit;
      tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      tbl[1] = '{8'hCC, 1'b1, 1'b1, 8'hCC, 1'b1, 1'b0};
      tbl[2] = '{8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
      tbl[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
      tbl[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[6] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
      tick_n(3);
      chk("rst_data", data_out, 0);
      chk("rst_dv", data_valid, 0);
      chk("rst_perr", parity_error, 0);
      chk("rst_ferr", frame_error, 0);
      chk("rst_busy", busy, 0);
      rst = 0;
      tick_n(2);
      for (int v = 0; v < 7; v++) begin
         send(tbl[v].d, ^tbl[v].d ^ 1'(PARITY_ODD) ^ tbl[v].flip, tbl[v].stop, t0);
         check_obs($sformatf("tbl%0d", v), tbl[v].xd, tbl[v].xpe, tbl[v].xfe, t0);
         chk($sformatf("tbl%0d_busy_after", v), busy, !tbl[v].stop);
         if (!tbl[v].stop) begin
            for (int i = 0; i < 10; i++) begin
               tick_n(1);
               chk($sformatf("tbl%0d_break_busy", v), busy, 1);
            end
            serial_in = 1;
            tick_n(1);
            chk($sformatf("tbl%0d_break_exit", v), busy, 0);
         end
      end
      serial_in = 0;
      tick_n(1);
      serial_in = 1;
      chk("glitch_busy", busy, 1);
      tick_n(2);
      chk("glitch_idle", busy, 0);
      tick_n(40);
      chk("glitch_no_dv", mq.size(), 0);
      chk("glitch_data_held", data_out, 8'h5A);
      d = 8'h81;
      bit_out(1'b0);
      for (int i = 0; i < 3; i++) bit_out(d[i]);
      serial_in = d[3];
      tick_n(2);
      rst = 1;
      serial_in = 1;
      tick_n(1);
      chk("midrst_data", data_out, 0);
      chk("midrst_dv", data_valid, 0);
      chk("midrst_perr", parity_error, 0);
      chk("midrst_ferr", frame_error, 0);
      chk("midrst_busy", busy, 0);
      rst = 0;
      tick_n(50);
      chk("midrst_no_dv", mq.size(), 0);
      send(8'h7E, ^8'h7E ^ 1'(PARITY_ODD), 1'b1, t0);
      check_obs("after_rst", 8'h7E, 1'b0, 1'b0, t0);
      for (int r = 0; r < 40; r++) begin
         d = 8'($urandom);
         flip = $urandom_range(0, 3) == 0;
         stop = $urandom_range(0, 7) != 0;
         pbit = ^d ^ 1'(PARITY_ODD) ^ flip;
         send(d, pbit, stop, t0);
         check_obs($sformatf("rnd%0d", r), d, (^d ^ pbit) != 1'(PARITY_ODD), ~stop, t0);
         chk($sformatf("rnd%0d_busy", r), busy, !stop);
         if (stop) tick_n($urandom_range(0, 3));
         else begin
            tick_n($urandom_range(0, 5));
            serial_in = 1;
            tick_n($urandom_range(1, 3));
         end
      end
`ifdef PFR_ERR_COUNT_EN
      rst = 1;
      tick_n(1);
      rst = 0;
      chk("ec_rst", err_count, 0);
      for (int i = 0; i < 3; i++) send(8'h11 * i, ~(^(8'h11 * i)) ^ 1'(PARITY_ODD), 1'b1, t0);
      send(8'h42, ^8'h42 ^ 1'(PARITY_ODD), 1'b1, t0);
      tick_n(1);
      chk("ec_three", err_count, 3);
      for (int i = 0; i < 260; i++) send(8'hA0, ~(^8'hA0) ^ 1'(PARITY_ODD), 1'b1, t0);
      tick_n(1);
      chk("ec_saturate", err_count, 255);
      mq.delete();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
